qbert_test2_cpu_cpu_debug_host: RTL and testbench

QBERT_TEST2_CPU_CPU_DEBUG_HOST -- requirements
Module: qbert_test2_cpu_cpu_debug_host

---
 rtl/qbert_test2_cpu_cpu_debug_pkg.sv | 29 ++
 rtl/qbert_test2_cpu_cpu_debug_host_shifter.sv | 49 ++++
 rtl/qbert_test2_cpu_cpu_debug_host.sv | 147 ++++++++++++++
 tb/tb_qbert_test2_cpu_cpu_debug_host.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/qbert_test2_cpu_cpu_debug_pkg.sv
// Shared definitions for the CPU debug host: default sizes, virtual IR codes
// and the scan sequencer state type.
package qbert_test2_cpu_cpu_debug_pkg;

   localparam int unsigned DATA_W_DEF = 38;
   localparam int unsigned IR_W_DEF   = 2;

   // Virtual instruction register codes understood by the debug slave
   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RSP
   } host_state_t;

   // Bit-counter width: ceil(log2(w)), never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/qbert_test2_cpu_cpu_debug_host_shifter.sv
// Scan data register and bit counter for the debug host.
// Data shifts right (LSB out first) with the serial input entering the MSB;
// done is high when the counter has reached zero.
module qbert_test2_cpu_cpu_debug_host_shifter
   import qbert_test2_cpu_cpu_debug_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic              shift,
   input  logic              tdo,
   output logic [DATA_W-1:0] data,
   output logic              done
);

   localparam int unsigned     CNT_W    = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0] cnt;

   // Shift register: parallel load on command accept, serial shift during SDR
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {tdo, data[DATA_W-1:1]};
      end
   end

   // Bit counter: preset in CDR, counts down in SDR and parks at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CNT_INIT;
      end else if (shift && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/qbert_test2_cpu_cpu_debug_host.sv
// CPU debug host: turns one command (IR + data) into a virtual JTAG scan
// sequence UIR -> CDR -> SDR x DATA_W -> UDR [-> RTI] and returns the
// shifted-out data with a valid/ready response.
// Optional feature: define QBERT_DEBUG_HOST_RTI_EN to pass through a one-cycle
// RTI state (vji_rti) between UDR and the response.
module qbert_test2_cpu_cpu_debug_host
   import qbert_test2_cpu_cpu_debug_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IR_W   = IR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [IR_W-1:0]   cmd_ir,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [IR_W-1:0]   rsp_ir_out,
   output logic [IR_W-1:0]   vji_ir_in,
   input  logic [IR_W-1:0]   vji_ir_out,
   output logic              vji_tdi,
   input  logic              vji_tdo,
   output logic              vji_uir,
   output logic              vji_cdr,
   output logic              vji_sdr,
   output logic              vji_udr,
   output logic              vji_rti,
   output logic              busy
);

   host_state_t       state, state_nxt;
   logic              sh_load, sh_start, sh_shift, sh_done;
   logic [DATA_W-1:0] sh_data;

   qbert_test2_cpu_cpu_debug_host_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (sh_load),
      .load_data (cmd_data),
      .start     (sh_start),
      .shift     (sh_shift),
      .tdo       (vji_tdo),
      .data      (sh_data),
      .done      (sh_done)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and per-state qualifiers
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      vji_uir   = 1'b0;
      vji_cdr   = 1'b0;
      vji_sdr   = 1'b0;
      vji_udr   = 1'b0;
      vji_rti   = 1'b0;
      vji_tdi   = 1'b0;
      sh_load   = 1'b0;
      sh_start  = 1'b0;
      sh_shift  = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               sh_load   = 1'b1;
               state_nxt = ST_UIR;
            end
         end
         ST_UIR: begin
            vji_uir   = 1'b1;
            state_nxt = ST_CDR;
         end
         ST_CDR: begin
            vji_cdr   = 1'b1;
            sh_start  = 1'b1;
            state_nxt = ST_SDR;
         end
         ST_SDR: begin
            vji_sdr  = 1'b1;
            sh_shift = 1'b1;
            vji_tdi  = sh_data[0];
            if (sh_done) begin
               state_nxt = ST_UDR;
            end
         end
         ST_UDR: begin
            vji_udr = 1'b1;
`ifdef QBERT_DEBUG_HOST_RTI_EN
            state_nxt = ST_RTI;
`else
            state_nxt = ST_RSP;
`endif
         end
         ST_RTI: begin
`ifdef QBERT_DEBUG_HOST_RTI_EN
            vji_rti = 1'b1;
`endif
            state_nxt = ST_RSP;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Instruction to slave, held from accept until the next accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vji_ir_in <= '0;
      end else if (sh_load) begin
         vji_ir_in <= cmd_ir;
      end
   end

   // Slave status captured during UIR
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_ir_out <= '0;
      end else if (state == ST_UIR) begin
         rsp_ir_out <= vji_ir_out;
      end
   end

   assign rsp_data = sh_data;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_qbert_test2_cpu_cpu_debug_host.sv
// Self-checking bench for qbert_test2_cpu_cpu_debug_host: directed scans
// (loopback, all-ones, response back-pressure, mid-scan reset) plus random
// scans, all compared against a cycle-timeline model of the scan sequence.
module tb_qbert_test2_cpu_cpu_debug_host;
   import qbert_test2_cpu_cpu_debug_pkg::*;

   localparam int DW = 38;
   localparam int IW = 2;
`ifdef QBERT_DEBUG_HOST_RTI_EN
   localparam int RSP_CYC = DW + 5;
`else
   localparam int RSP_CYC = DW + 4;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [IW-1:0] cmd_ir = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic [IW-1:0] rsp_ir_out;
   logic [IW-1:0] vji_ir_in;
   logic [IW-1:0] vji_ir_out = '0;
   logic          vji_tdi;
   logic          vji_tdo = 1'b0;
   logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   qbert_test2_cpu_cpu_debug_host #(
      .DATA_W (DW),
      .IR_W   (IW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ir     (cmd_ir),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_ir_out (rsp_ir_out),
      .vji_ir_in  (vji_ir_in),
      .vji_ir_out (vji_ir_out),
      .vji_tdi    (vji_tdi),
      .vji_tdo    (vji_tdo),
      .vji_uir    (vji_uir),
      .vji_cdr    (vji_cdr),
      .vji_sdr    (vji_sdr),
      .vji_udr    (vji_udr),
      .vji_rti    (vji_rti),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {uir,cdr,sdr,udr,rti,rsp_valid,busy,cmd_ready,tdi}
   function automatic logic [8:0] obs_vec();
      return {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid, busy, cmd_ready, vji_tdi};
   endfunction

   // Expected outputs c cycles after the accept cycle: the scan timeline
   function automatic logic [8:0] exp_vec(input int c, input logic [DW-1:0] data);
      logic [8:0] e;
      e = 9'b000000100;
      if (c == 1)                    e[8] = 1'b1;
      else if (c == 2)               e[7] = 1'b1;
      else if (c >= 3 && c <= DW+2) begin
         e[6] = 1'b1;
         e[0] = data[c-3];
      end
      else if (c == DW+3)            e[5] = 1'b1;
      else if (c >= RSP_CYC)         e[3] = 1'b1;
      else                           e[4] = 1'b1;
      return e;
   endfunction

   localparam logic [8:0] IDLE_VEC = 9'b000000010;

   // mode: 0 random tdo, 1 registered loopback of tdi, 2 tdo tied high
   task automatic run_scan(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                           input logic [IW-1:0] irout, input int mode, input int hold,
                           input int abort_at, input bit keep_valid,
                           output logic [DW-1:0] last_rsp);
      logic [DW-1:0] exp_rsp;
      logic          prev_tdi, cur_tdi;
      exp_rsp  = '0;
      last_rsp = '0;
      check("accept_ready", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_ir     = ir;
      cmd_data   = data;
      vji_ir_out = irout;
      rsp_ready  = 1'($urandom_range(0, 1));
      prev_tdi   = vji_tdi;
      vji_tdo    = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int c = 1; c <= RSP_CYC + hold + 1; c++) begin
         @(posedge clk);
         #1;
         if (keep_valid) begin
            cmd_ir   = ~ir;
            cmd_data = ~data;
         end else begin
            cmd_valid = 1'b0;
         end
         if (c == abort_at) begin
            cmd_valid = 1'b0;
            reset_n   = 1'b0;
            #1;
            check("rst_quals", obs_vec(), IDLE_VEC);
            check("rst_ir_in", vji_ir_in, 0);
            check("rst_ir_out", rsp_ir_out, 0);
            check("rst_rsp_data", rsp_data, 0);
            vji_tdo = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         if (c == RSP_CYC + hold + 1) begin
            check("back_to_idle", obs_vec(), IDLE_VEC);
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            return;
         end
         check("timeline", obs_vec(), exp_vec(c, data));
         check("ir_in_held", vji_ir_in, ir);
         if (c >= 2) check("ir_out_capt", rsp_ir_out, irout);
         if (c >= RSP_CYC) begin
            check("rsp_data", rsp_data, exp_rsp);
            last_rsp  = rsp_data;
            rsp_ready = (c == RSP_CYC + hold);
         end else begin
            rsp_ready = 1'($urandom_range(0, 1));
         end
         cur_tdi = vji_tdi;
         case (mode)
            1:       vji_tdo = prev_tdi;
            2:       vji_tdo = 1'b1;
            default: vji_tdo = 1'($urandom_range(0, 1));
         endcase
         prev_tdi = cur_tdi;
         if (c >= 3 && c <= DW+2) exp_rsp[c-3] = vji_tdo;
      end
   endtask

   initial begin
      logic [DW-1:0] d, r, e;
      logic [IW-1:0] ir, io;

      repeat (3) @(posedge clk);
      #1;
      check("reset_quals", obs_vec(), IDLE_VEC);
      check("reset_ir_in", vji_ir_in, 0);
      check("reset_ir_out", rsp_ir_out, 0);
      check("reset_rsp_data", rsp_data, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Registered loopback: response is command data moved up one bit
      d = 38'h2A_5A5A_5A5A;
      run_scan(IR_BREAK, d, 2'($urandom), 1, 0, -1, 1'b0, r);
      e = d << 1;
      check("loopback_data", r, e);

      // tdo tied high with zero data
      run_scan(IR_OCIMEM, '0, 2'($urandom), 2, 1, -1, 1'b0, r);
      check("all_ones", r, 38'h3F_FFFF_FFFF);

      // Slave status capture and response timing
      run_scan(IR_TRACEMEM, {$urandom, $urandom}, 2'b01, 0, 0, -1, 1'b0, r);

      // Response held off while a new command keeps requesting
      run_scan(IR_TRACECTRL, {$urandom, $urandom}, 2'b10, 0, 10, -1, 1'b1, r);
      run_scan(IR_OCIMEM, {$urandom, $urandom}, 2'b11, 0, 0, -1, 1'b0, r);

      // Reset in the middle of SDR (bit 17), then a complete scan
      run_scan(IR_BREAK, {$urandom, $urandom}, 2'b11, 0, 0, 3 + 17, 1'b0, r);
      run_scan(IR_TRACEMEM, {$urandom, $urandom}, 2'b10, 1, 2, -1, 1'b0, r);

      for (int i = 0; i < 8; i++) begin
         d  = {$urandom, $urandom};
         ir = 2'($urandom);
         io = 2'($urandom);
         run_scan(ir, d, io, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                  -1, 1'($urandom_range(0, 1)), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
